vga_fill_master: RTL and testbench

VGA_FILL_MASTER -- requirements
Module: vga_fill_master

---
 rtl/vga_fill_master.sv | 147 ++++++++++++++
 tb/tb_vga_fill_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_fill_master.sv
// vga_fill_master: Avalon-MM master that fills a word range with a constant or incrementing pattern.
// Define VGA_FILL_VERIFY_EN to add a read-back pass flagging the first mismatching address on ERR/ERR_ADDR.
module vga_fill_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] LENGTH,
    input  logic [DATA_W-1:0] FILL_DATA,
    input  logic              INCR,
    output logic              BUSY,
    output logic              DONE,
    output logic              AVM_CS,
    output logic              AVM_WRITE,
    output logic              AVM_READ,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic [3:0]        AVM_BYTE_EN,
    output logic [DATA_W-1:0] AVM_WRITEDATA,
    input  logic              AVM_WAITREQUEST,
    input  logic [DATA_W-1:0] AVM_READDATA,
    input  logic              AVM_READDATAVALID,
    output logic              ERR,
    output logic [ADDR_W-1:0] ERR_ADDR
);
`ifdef VGA_FILL_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, FIN} state_t;
`endif
    state_t r_state;
    logic [ADDR_W-1:0] r_addr, r_cnt;
    logic [DATA_W-1:0] r_pat;
    logic r_incr, r_write, r_busy, r_done;
    logic w_wr_acc, w_last;
    assign w_wr_acc = r_write && !AVM_WAITREQUEST;
    assign w_last = r_cnt == ADDR_W'(1);
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign AVM_WRITE = r_write;
    assign AVM_ADDR = r_addr;
    assign AVM_WRITEDATA = r_pat;
    assign AVM_BYTE_EN = 4'hF;
`ifdef VGA_FILL_VERIFY_EN
    logic r_read, r_err;
    logic [ADDR_W-1:0] r_err_addr, r_base, r_len;
    logic [DATA_W-1:0] r_fill;
    assign AVM_CS = r_write | r_read;
    assign AVM_READ = r_read;
    assign ERR = r_err;
    assign ERR_ADDR = r_err_addr;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{AVM_READDATA, AVM_READDATAVALID};
    assign AVM_CS = r_write;
    assign AVM_READ = 1'b0;
    assign ERR = 1'b0;
    assign ERR_ADDR = '0;
`endif
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_addr <= '0;
            r_cnt <= '0;
            r_pat <= '0;
            r_incr <= 1'b0;
            r_write <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
`ifdef VGA_FILL_VERIFY_EN
            r_read <= 1'b0;
            r_err <= 1'b0;
            r_err_addr <= '0;
            r_base <= '0;
            r_len <= '0;
            r_fill <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (START) begin
                    r_addr <= BASE_ADDR;
                    r_cnt <= LENGTH;
                    r_pat <= FILL_DATA;
                    r_incr <= INCR;
                    r_busy <= 1'b1;
                    r_write <= LENGTH != '0;
                    r_state <= (LENGTH == '0) ? FIN : WR;
`ifdef VGA_FILL_VERIFY_EN
                    r_base <= BASE_ADDR;
                    r_len <= LENGTH;
                    r_fill <= FILL_DATA;
                    r_err <= 1'b0;
                    r_err_addr <= '0;
`endif
                end
                WR: if (w_wr_acc) begin
                    r_addr <= r_addr + 1'b1;
                    r_pat <= r_pat + DATA_W'(r_incr);
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_write <= 1'b0;
`ifdef VGA_FILL_VERIFY_EN
                        // Rewind to regenerate the same pattern for the read-back pass
                        r_addr <= r_base;
                        r_pat <= r_fill;
                        r_cnt <= r_len;
                        r_read <= 1'b1;
                        r_state <= RD;
`else
                        r_done <= 1'b1;
                        r_state <= FIN;
`endif
                    end
                end
`ifdef VGA_FILL_VERIFY_EN
                RD: if (!AVM_WAITREQUEST) begin
                    r_read <= 1'b0;
                    r_state <= RWAIT;
                end
                RWAIT: if (AVM_READDATAVALID) begin
                    if (AVM_READDATA != r_pat && !r_err) begin
                        r_err <= 1'b1;
                        r_err_addr <= r_addr;
                    end
                    r_addr <= r_addr + 1'b1;
                    r_pat <= r_pat + DATA_W'(r_incr);
                    r_cnt <= r_cnt - 1'b1;
                    r_done <= w_last;
                    r_read <= !w_last;
                    r_state <= w_last ? FIN : RD;
                end
`endif
                // Zero-length commands arrive without DONE set and spend one extra cycle here
                FIN: if (r_done) begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fill_master.sv
// tb_vga_fill_master: directed bench for vga_fill_master with a write log and a small memory slave.
module tb_vga_fill_master;
`ifdef VGA_FILL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    logic CLK = 1'b0, RESET = 1'b0, START = 1'b0, INCR = 1'b0;
    logic [11:0] BASE_ADDR = '0, LENGTH = '0, AVM_ADDR, ERR_ADDR;
    logic [31:0] FILL_DATA = '0, AVM_WRITEDATA, rdata;
    logic BUSY, DONE, AVM_CS, AVM_WRITE, AVM_READ, ERR, rdv;
    logic [3:0] AVM_BYTE_EN;
    logic wreq = 1'b0;
    int n_chk = 0, n_pass = 0;
    int wr_total = 0, cs_total = 0, rd_total = 0, done_total = 0;
    logic [11:0] wr_a [0:63];
    logic [31:0] wr_d [0:63];
    logic [31:0] mem [0:4095];

    vga_fill_master #(.ADDR_W(12), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH),
        .FILL_DATA(FILL_DATA), .INCR(INCR), .BUSY(BUSY), .DONE(DONE), .AVM_CS(AVM_CS),
        .AVM_WRITE(AVM_WRITE), .AVM_READ(AVM_READ), .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(wreq), .AVM_READDATA(rdata),
        .AVM_READDATAVALID(rdv), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    // Slave memory corrupts address 0x012 on read-back; monitor logs accepted writes and pulse counts
    always @(posedge CLK) begin
        if (AVM_WRITE && !wreq) begin
            mem[AVM_ADDR] <= AVM_WRITEDATA;
            wr_a[wr_total % 64] <= AVM_ADDR;
            wr_d[wr_total % 64] <= AVM_WRITEDATA;
            wr_total <= wr_total + 1;
        end
        rdv <= AVM_READ && !wreq;
        rdata <= mem[AVM_ADDR] ^ ((AVM_ADDR == 12'h012) ? 32'h1 : 32'h0);
        if (AVM_CS) cs_total <= cs_total + 1;
        if (AVM_READ) rd_total <= rd_total + 1;
        if (DONE) done_total <= done_total + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_cmd(input logic [11:0] b, input logic [11:0] l, input logic [31:0] f, input logic inc);
        BASE_ADDR = b;
        LENGTH = l;
        FILL_DATA = f;
        INCR = inc;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!DONE && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, DONE}, 64'd1);
    endtask

    initial begin
        int b, c, d;
        rdv = 1'b0;
        rdata = '0;
        tick();
        tick();
        chk("rst_busy", {63'd0, BUSY}, 0);
        chk("rst_done", {63'd0, DONE}, 0);
        chk("rst_cs", {63'd0, AVM_CS}, 0);
        chk("rst_wr", {63'd0, AVM_WRITE}, 0);
        chk("rst_rd", {63'd0, AVM_READ}, 0);
        chk("rst_addr", {52'd0, AVM_ADDR}, 0);
        chk("rst_data", {32'd0, AVM_WRITEDATA}, 0);
        chk("rst_err", {63'd0, ERR}, 0);
        chk("byte_en", {60'd0, AVM_BYTE_EN}, 64'hF);
        RESET = 1'b1;
        tick();

        // Constant fill, no stalls: one word per cycle, DONE right after the last accept
        b = wr_total;
        start_cmd(12'h010, 12'd4, 32'hAABBCCDD, 1'b0);
        chk("t1_busy", {63'd0, BUSY}, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr", {63'd0, AVM_WRITE}, 1);
            chk("t1_addr", {52'd0, AVM_ADDR}, 64'h010 + i);
            chk("t1_data", {32'd0, AVM_WRITEDATA}, 64'hAABBCCDD);
            tick();
        end
        chk("t1_done_next", {63'd0, DONE}, VERIFY ? 64'd0 : 64'd1);
        chk("t1_wr_off", {63'd0, AVM_WRITE}, 0);
        wait_done("t1_done");
        tick();
        chk("t1_done_pulse", {63'd0, DONE}, 0);
        chk("t1_busy_off", {63'd0, BUSY}, 0);
        chk("t1_count", wr_total - b, 4);

        // Incrementing fill across the address wrap
        b = wr_total;
        start_cmd(12'hFFE, 12'd3, 32'hFFFFFFFF, 1'b1);
        wait_done("t2_done");
        tick();
        chk("t2_count", wr_total - b, 3);
        chk("t2_a0", {52'd0, wr_a[b % 64]}, 64'hFFE);
        chk("t2_a1", {52'd0, wr_a[(b + 1) % 64]}, 64'hFFF);
        chk("t2_a2", {52'd0, wr_a[(b + 2) % 64]}, 64'h000);
        chk("t2_d0", {32'd0, wr_d[b % 64]}, 64'hFFFFFFFF);
        chk("t2_d1", {32'd0, wr_d[(b + 1) % 64]}, 64'h0);
        chk("t2_d2", {32'd0, wr_d[(b + 2) % 64]}, 64'h1);

        // Stall the 2nd word for 3 cycles
        b = wr_total;
        start_cmd(12'h020, 12'd4, 32'h11111111, 1'b1);
        tick();
        wreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_wr", {63'd0, AVM_WRITE}, 1);
            chk("t3_hold_addr", {52'd0, AVM_ADDR}, 64'h021);
            chk("t3_hold_data", {32'd0, AVM_WRITEDATA}, 64'h11111112);
        end
        wreq = 1'b0;
        wait_done("t3_done");
        tick();
        chk("t3_count", wr_total - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_addr", {52'd0, wr_a[(b + i) % 64]}, 64'h020 + i);
            chk("t3_data", {32'd0, wr_d[(b + i) % 64]}, 64'h11111111 + i);
        end

        // Zero length, plus STARTs while busy and during DONE
        c = cs_total;
        start_cmd(12'h100, 12'd0, 32'h12345678, 1'b0);
        chk("t4_busy", {63'd0, BUSY}, 1);
        chk("t4_done_early", {63'd0, DONE}, 0);
        start_cmd(12'h200, 12'd5, 32'h1, 1'b0);
        chk("t4_done", {63'd0, DONE}, 1);
        start_cmd(12'h300, 12'd2, 32'h2, 1'b0);
        chk("t4_done_pulse", {63'd0, DONE}, 0);
        chk("t4_busy_off", {63'd0, BUSY}, 0);
        tick();
        tick();
        chk("t4_ignored", {63'd0, BUSY}, 0);
        chk("t4_no_cs", cs_total - c, 0);

        // Reset during the 3rd write, no resume after release
        b = wr_total;
        start_cmd(12'h030, 12'd6, 32'h5, 1'b0);
        tick();
        tick();
        chk("t5_third", {52'd0, AVM_ADDR}, 64'h032);
        RESET = 1'b0;
        #1;
        chk("t5_rst_wr", {63'd0, AVM_WRITE}, 0);
        chk("t5_rst_cs", {63'd0, AVM_CS}, 0);
        chk("t5_rst_addr", {52'd0, AVM_ADDR}, 0);
        chk("t5_rst_data", {32'd0, AVM_WRITEDATA}, 0);
        chk("t5_rst_busy", {63'd0, BUSY}, 0);
        tick();
        RESET = 1'b1;
        d = done_total;
        b = wr_total;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_no_done", done_total - d, 0);
        chk("t5_no_resume", wr_total - b, 0);
        chk("t5_idle", {63'd0, BUSY}, 0);

`ifdef VGA_FILL_VERIFY_EN
        start_cmd(12'h010, 12'd4, 32'hAABBCCDD, 1'b0);
        wait_done("v_done");
        chk("v_err", {63'd0, ERR}, 1);
        chk("v_err_addr", {52'd0, ERR_ADDR}, 64'h012);
        tick();
        start_cmd(12'h400, 12'd0, 32'h0, 1'b0);
        chk("v_err_clr", {63'd0, ERR}, 0);
        wait_done("v_done2");
        tick();
`else
        chk("no_read", rd_total, 0);
        chk("err_off", {63'd0, ERR}, 0);
        chk("err_addr_off", {52'd0, ERR_ADDR}, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
